// File: rtl/seq_divider_if.sv
// Start/ready/done handshake and operand/result bundle for the sequential divider.
// master drives requests, slave is the divider itself.
interface seq_divider_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// state | meaning
// IDLE  | ready for a request, results held
// CALC  | shifting dividend through the partial remainder, DW iterations
// DONE  | one-cycle done pulse, results valid
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input logic         clk,
  input logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [DW-1:0] q_work;
  logic [VW:0]   r_work;
  logic [VW-1:0] dvs_q;
  logic [CW-1:0] cnt;

  logic [VW:0]   shifted;
  logic [VW:0]   trial;
  logic          fits;
  logic [VW:0]   r_next;
  logic [DW-1:0] q_next;

  // Trial subtraction: a clear MSB means the divisor fits into the shifted remainder.
  assign shifted = {r_work[VW-1:0], q_work[DW-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign fits    = ~trial[VW];
  assign r_next  = fits ? trial : shifted;
  assign q_next  = {q_work[DW-2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.ready       <= 1'b1;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      q_work          <= '0;
      r_work          <= '0;
      dvs_q           <= '0;
      cnt             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.ready       <= 1'b0;
            bus.div_by_zero <= 1'b0;
            dvs_q           <= bus.divisor;
            if (bus.divisor == '0) begin
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend[VW-1:0];
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
              state           <= DONE;
            end else begin
              q_work <= bus.dividend;
              r_work <= '0;
              cnt    <= CW'(DW - 1);
              state  <= CALC;
            end
          end
        end
        CALC: begin
          q_work <= q_next;
          r_work <= r_next;
          if (cnt == '0) begin
            bus.quotient  <= q_next;
            bus.remainder <= r_next[VW-1:0];
            bus.done      <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
